// File: rtl/chord_sequencer_if.sv
// Song-ROM read port plus the note-load command bundle between the
// sequencer (master) and the ROM / note distributor side (slave).
interface chord_sequencer_if #(
    parameter int unsigned SONG_BITS  = 2,
    parameter int unsigned ENTRY_BITS = 5
) ();
    logic [SONG_BITS+ENTRY_BITS-1:0] rom_addr;
    logic [15:0]                     rom_data;
    logic                            load_new_note;
    logic [5:0]                      note_to_load;
    logic [5:0]                      duration_to_load;

    modport master (
        output rom_addr,
        input  rom_data,
        output load_new_note,
        output note_to_load,
        output duration_to_load
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  load_new_note,
        input  note_to_load,
        input  duration_to_load
    );
endinterface

// File: rtl/chord_sequencer.sv
// Walks one song in the ROM, pulsing note loads back-to-back (chords) and
// holding off on wait entries for a number of beats.
module chord_sequencer #(
    parameter int unsigned SONG_BITS  = 2,
    parameter int unsigned ENTRY_BITS = 5,
    parameter int unsigned LOAD_GAP   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 play,
    input  logic                 beat,
    input  logic [SONG_BITS-1:0] song,
    output logic                 song_done,
    chord_sequencer_if.master    bus
);
    localparam int unsigned GcntBits = $clog2(LOAD_GAP + 1);

    typedef enum logic [2:0] {
        StFetch, StDecode, StLoad, StGap, StWait, StNext, StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ENTRY_BITS-1:0] idx_q, idx_d;
    logic [SONG_BITS-1:0]  song_q, song_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [GcntBits-1:0]   gcnt_q, gcnt_d;
    logic [5:0]            note_q, note_d;
    logic [5:0]            dur_q, dur_d;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            idx_q   <= '0;
            song_q  <= song;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            note_q  <= '0;
            dur_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            song_q  <= song_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
        end
    end

    // Next-state logic: song change restarts, otherwise walk the ROM entries.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        song_d  = song_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        note_d  = note_q;
        dur_d   = dur_q;

        // LOAD is exempt so its pulse always completes; the restart follows in GAP.
        if (song != song_q && state_q != StLoad) begin
            song_d  = song;
            idx_d   = '0;
            cnt_d   = '0;
            gcnt_d  = '0;
            state_d = StFetch;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (play) state_d = StDecode;
                end
                StDecode: begin
                    if (play) begin
                        if (bus.rom_data == 16'h0000) begin
                            state_d = StDone;
                        end else if (!bus.rom_data[15]) begin
                            note_d  = bus.rom_data[14:9];
                            dur_d   = bus.rom_data[5:0];
                            state_d = StLoad;
                        end else if (bus.rom_data[5:0] != 6'd0) begin
                            cnt_d   = bus.rom_data[5:0];
                            state_d = StWait;
                        end else begin
                            state_d = StNext;
                        end
                    end
                end
                StLoad: begin
                    // The LOAD cycle itself is the first of the LOAD_GAP idle ticks,
                    // so GAP lasts LOAD_GAP-1 cycles and NEXT is the last idle cycle.
                    gcnt_d  = GcntBits'(LOAD_GAP - 1);
                    state_d = (LOAD_GAP > 1) ? StGap : StNext;
                end
                StGap: begin
                    // Keeps counting while paused; the pause takes hold in NEXT.
                    gcnt_d = gcnt_q - 1'b1;
                    if (gcnt_q <= GcntBits'(1)) state_d = StNext;
                end
                StWait: begin
                    if (play && beat) begin
                        if (cnt_q == 6'd1) begin
                            cnt_d   = '0;
                            state_d = StNext;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                StNext: begin
                    if (play) begin
                        if (idx_q == '1) begin
                            state_d = StDone;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = StFetch;
                        end
                    end
                end
                StDone: begin
                    state_d = StDone;
                end
                default: state_d = StFetch;
            endcase
        end
    end

    // Moore outputs straight from registers.
    always_comb begin
        bus.rom_addr         = {song_q, idx_q};
        bus.load_new_note    = (state_q == StLoad);
        bus.note_to_load     = note_q;
        bus.duration_to_load = dur_q;
        song_done            = (state_q == StDone);
    end
endmodule

// File: tb/tb_chord_sequencer.sv
// Directed bench for chord_sequencer with a synchronous song ROM model.
module tb_chord_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic       beat;
    logic [1:0] song;
    logic       song_done;

    logic [15:0] mem [0:127];
    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;
    int base;
    int n;

    chord_sequencer_if #(.SONG_BITS(2), .ENTRY_BITS(5)) bus ();

    chord_sequencer #(.SONG_BITS(2), .ENTRY_BITS(5), .LOAD_GAP(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .beat      (beat),
        .song      (song),
        .song_done (song_done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data valid the cycle after the address.
    always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

    // Count load pulses away from the active edge.
    always @(negedge clk) if (bus.load_new_note === 1'b1) pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic do_reset(input logic [1:0] s);
        song  = s;
        reset = 1'b1;
        tick();
        check("rst_load", 32'(bus.load_new_note), 0);
        check("rst_done", 32'(song_done), 0);
        check("rst_addr", 32'(bus.rom_addr), 32'(s) * 32);
        check("rst_note", 32'(bus.note_to_load), 0);
        check("rst_dur", 32'(bus.duration_to_load), 0);
        reset = 1'b0;
    endtask

    // Cycles until the next pulse, or -1 if the bound expires.
    task automatic wait_pulse(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (bus.load_new_note !== 1'b1 && cyc < max_cyc);
        if (bus.load_new_note !== 1'b1) cyc = -1;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (song_done !== 1'b1 && cyc < max_cyc);
        if (song_done !== 1'b1) cyc = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        play  = 1'b1;
        beat  = 1'b0;
        song  = 2'd0;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        // Song 0: A, B, C, wait 4, end.
        mem[0]  = 16'((10 << 9) | 3);
        mem[1]  = 16'((20 << 9) | 5);
        mem[2]  = 16'((30 << 9) | 7);
        mem[3]  = 16'h8004;
        // Song 1: wait 3, D, end.
        mem[32] = 16'h8003;
        mem[33] = 16'((40 << 9) | 9);
        // Song 2: note, wait 0, note, end.
        mem[64] = 16'((5 << 9) | 1);
        mem[65] = 16'h8000;
        mem[66] = 16'((6 << 9) | 2);
        // Song 3: 32 notes, no end marker.
        for (int i = 0; i < 32; i++) mem[96+i] = 16'(((i + 1) << 9) | (i + 1));

        // 1: chord of three notes, then a 4-beat wait and the end marker.
        do_reset(2'd0);
        tick(); tick();
        check("t1_first_pulse", 32'(bus.load_new_note), 1);
        check("t1_note_a", 32'(bus.note_to_load), 10);
        check("t1_dur_a", 32'(bus.duration_to_load), 3);
        wait_pulse(20, n);
        check("t1_gap_b", n, 5);
        check("t1_note_b", 32'(bus.note_to_load), 20);
        check("t1_dur_b", 32'(bus.duration_to_load), 5);
        wait_pulse(20, n);
        check("t1_gap_c", n, 5);
        check("t1_note_c", 32'(bus.note_to_load), 30);
        check("t1_dur_c", 32'(bus.duration_to_load), 7);
        repeat (10) tick();
        check("t1_wait_addr", 32'(bus.rom_addr), 3);
        repeat (3) begin
            pulse_beat();
            repeat (3) tick();
        end
        check("t1_three_beats_addr", 32'(bus.rom_addr), 3);
        check("t1_three_beats_done", 32'(song_done), 0);
        pulse_beat();
        wait_done(20, n);
        check("t1_done_latency", n, 3);
        check("t1_done_addr", 32'(bus.rom_addr), 4);
        base = pulses;
        repeat (5) pulse_beat();
        check("t1_done_stays", 32'(song_done), 1);
        check("t1_no_loads_after_done", pulses - base, 0);
        song = 2'd2;
        tick();
        check("t1_change_clears_done", 32'(song_done), 0);
        check("t1_change_addr", 32'(bus.rom_addr), 64);

        // 2: pause mid-wait; beats while paused must not count.
        do_reset(2'd1);
        tick(); tick();
        pulse_beat();
        base = pulses;
        play = 1'b0;
        repeat (5) begin
            pulse_beat();
            tick();
        end
        check("t2_pause_addr", 32'(bus.rom_addr), 32);
        play = 1'b1;
        pulse_beat();
        repeat (6) tick();
        check("t2_no_early_load", pulses - base, 0);
        pulse_beat();
        wait_pulse(10, n);
        check("t2_resume_latency", n, 3);
        check("t2_note_d", 32'(bus.note_to_load), 40);

        // 3: a wait-0 entry adds exactly three cycles.
        do_reset(2'd2);
        tick(); tick();
        check("t3_first_pulse", 32'(bus.load_new_note), 1);
        check("t3_first_note", 32'(bus.note_to_load), 5);
        wait_pulse(30, n);
        check("t3_gap_wait0", n, 8);
        check("t3_second_note", 32'(bus.note_to_load), 6);
        check("t3_second_dur", 32'(bus.duration_to_load), 2);

        // 4: full song without an end marker.
        do_reset(2'd3);
        base = pulses;
        wait_done(400, n);
        check("t4_done", 32'(song_done), 1);
        check("t4_pulse_count", pulses - base, 32);
        check("t4_last_addr", 32'(bus.rom_addr), 127);
        check("t4_last_note", 32'(bus.note_to_load), 32);
        repeat (10) tick();
        check("t4_addr_no_wrap", 32'(bus.rom_addr), 127);
        check("t4_pulse_count_hold", pulses - base, 32);

        // 5: song change during a wait restarts immediately.
        do_reset(2'd0);
        tick(); tick();
        wait_pulse(20, n);
        wait_pulse(20, n);
        repeat (8) tick();
        check("t5_in_wait_addr", 32'(bus.rom_addr), 3);
        song = 2'd2;
        tick();
        check("t5_restart_addr", 32'(bus.rom_addr), 64);
        check("t5_restart_done", 32'(song_done), 0);
        check("t5_restart_load", 32'(bus.load_new_note), 0);
        tick(); tick();
        check("t5_new_pulse", 32'(bus.load_new_note), 1);
        check("t5_new_note", 32'(bus.note_to_load), 5);

        // 6: reset in GAP and in WAIT.
        do_reset(2'd0);
        tick(); tick();
        tick();
        reset = 1'b1;
        tick();
        check("t6_gap_rst_addr", 32'(bus.rom_addr), 0);
        check("t6_gap_rst_load", 32'(bus.load_new_note), 0);
        check("t6_gap_rst_note", 32'(bus.note_to_load), 0);
        reset = 1'b0;
        tick(); tick();
        check("t6_gap_restart_pulse", 32'(bus.load_new_note), 1);
        check("t6_gap_restart_note", 32'(bus.note_to_load), 10);
        do_reset(2'd1);
        tick(); tick();
        pulse_beat();
        reset = 1'b1;
        tick();
        check("t6_wait_rst_addr", 32'(bus.rom_addr), 32);
        check("t6_wait_rst_load", 32'(bus.load_new_note), 0);
        check("t6_wait_rst_done", 32'(song_done), 0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
